// File: rtl/program_loader.sv
// program_loader: streams a program into instruction memory, verifies its additive checksum, then releases core reset.
module program_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          s_valid,
    input  logic [31:0]   s_data,
    output logic          s_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          core_rst,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW:0]   word_count
);
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, ERROR} state_t;
    localparam logic [AW:0] ONE     = 1;
    localparam logic [AW:0] MAX_LEN = (AW+1)'(DEPTH);
    state_t      state;
    logic [AW:0] len_q;
    logic [31:0] checksum;
    logic        xfer;
    logic        len_ok;
    logic [AW:0] wc_next;
    assign xfer     = s_valid && s_ready;
    assign len_ok   = (len != '0) && (len <= MAX_LEN);
    assign wc_next  = word_count + ONE;
    assign s_ready  = (state == LOAD) || (state == CHECK);
    assign busy     = s_ready;
    assign done     = state == RUN;
    assign error    = state == ERROR;
    assign core_rst = state != RUN;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            len_q      <= '0;
            checksum   <= '0;
            word_count <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE, RUN, ERROR: begin
                    // word_count is kept on a rejected start so the last load stays visible
                    if (start && len_ok) begin
                        state      <= LOAD;
                        len_q      <= len;
                        word_count <= '0;
                        checksum   <= '0;
                    end else if (start) begin
                        state <= ERROR;
                    end
                end
                LOAD: if (xfer) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= word_count[AW-1:0];
                    imem_wdata <= s_data;
                    word_count <= wc_next;
                    checksum   <= checksum + s_data;
                    if (wc_next == len_q) state <= CHECK;
                end
                CHECK: if (xfer) state <= (s_data == checksum) ? RUN : ERROR;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized directed bench for program_loader against a word-list/arithmetic-sum model.
module tb_program_loader;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   len;
    logic          s_valid;
    logic [31:0]   s_data;
    logic          s_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   word_count;
    int errors = 0;
    int checks = 0;
    int last_wc = 0;

    program_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .busy(busy), .done(done), .error(error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sum_of(input logic [31:0] w[$]);
        logic [31:0] s = '0;
        foreach (w[i]) s += w[i];
        return s;
    endfunction

    task automatic chk_reset_values(input string tag);
        chk({tag, "_core_rst"}, core_rst, 1);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_we"}, imem_we, 0);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_wdata"}, imem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_wc"}, word_count, 0);
    endtask

    task automatic send_word(input logic [31:0] d, input bit is_write, input int idx, input int stall_max);
        int n = int'($urandom_range(stall_max, 0));
        repeat (n) begin
            s_valid = 1'b0;
            s_data  = $urandom;
            @(posedge clk);
            @(negedge clk);
            chk("stall_we", imem_we, 0);
            chk("stall_wc", word_count, idx);
        end
        chk("ready", s_ready, 1);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        if (is_write) begin
            chk("we", imem_we, 1);
            chk("addr", imem_addr, idx);
            chk("wdata", imem_wdata, d);
            chk("wc", word_count, idx + 1);
        end else begin
            chk("cks_no_write", imem_we, 0);
        end
    endtask

    task automatic do_start(input int l);
        bit ok = (l >= 1) && (l <= DEPTH);
        start = 1'b1;
        len   = l[AW:0];
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, ok);
        chk("start_ready", s_ready, ok);
        chk("start_error", error, !ok);
        chk("start_done", done, 0);
        chk("start_core_rst", core_rst, 1);
        chk("start_we", imem_we, 0);
        chk("start_wc", word_count, ok ? 0 : last_wc);
    endtask

    task automatic load(input logic [31:0] w[$], input logic [31:0] cks, input int stall_max);
        bit ok = (cks == sum_of(w));
        do_start(w.size());
        foreach (w[i]) send_word(w[i], 1'b1, i, stall_max);
        send_word(cks, 1'b0, w.size(), stall_max);
        last_wc = w.size();
        chk("end_done", done, ok);
        chk("end_error", error, !ok);
        chk("end_core_rst", core_rst, !ok);
        chk("end_busy", busy, 0);
        chk("end_ready", s_ready, 0);
        chk("end_wc", word_count, last_wc);
    endtask

    initial begin
        logic [31:0] q[$];
        rst     = 1'b1;
        start   = 1'b0;
        len     = '0;
        s_valid = 1'b0;
        s_data  = '0;
        @(negedge clk);
        chk_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        q = '{32'h00500293, 32'h00A00313, 32'h006282B3};
        load(q, sum_of(q), 2);
        repeat (3) @(negedge clk);
        chk("run_hold_done", done, 1);
        chk("run_hold_wc", word_count, 3);

        q = '{$urandom, $urandom};
        load(q, sum_of(q), 2);

        q = '{32'h00500293, 32'h00A00313, 32'h006282B3};
        load(q, 32'h01100894, 1);
        q = '{32'h00000013};
        load(q, 32'h00000013, 1);

        do_start(0);
        do_start(65);
        repeat (2) @(negedge clk);
        chk("err_hold_ready", s_ready, 0);
        chk("err_hold_we", imem_we, 0);
        chk("err_hold_wc", word_count, last_wc);

        q = {};
        for (int i = 0; i < DEPTH; i++) q.push_back(32'hFFFFFFFF);
        load(q, 32'hFFFFFFC0, 3);

        q = '{$urandom, $urandom, $urandom, $urandom};
        do_start(4);
        send_word(q[0], 1'b1, 0, 1);
        send_word(q[1], 1'b1, 1, 1);
        start = 1'b1;
        len   = 7'd1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("ign_start_busy", busy, 1);
        chk("ign_start_wc", word_count, 2);
        chk("ign_start_error", error, 0);
        rst = 1'b1;
        #1;
        chk_reset_values("async_rst");
        @(negedge clk);
        rst = 1'b0;
        last_wc = 0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            @(posedge clk);
            @(negedge clk);
            chk("post_rst_we", imem_we, 0);
            chk("post_rst_ready", s_ready, 0);
            chk("post_rst_wc", word_count, 0);
        end
        s_valid = 1'b0;

        for (int t = 0; t < 6; t++) begin
            int n = int'($urandom_range(8, 1));
            logic [31:0] cks;
            q = {};
            for (int i = 0; i < n; i++) q.push_back($urandom);
            cks = sum_of(q);
            if ($urandom_range(1, 0) == 1) cks = cks ^ (32'h1 << $urandom_range(31, 0));
            load(q, cks, 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
